// File: rtl/cpu_pkg.sv
// Shared widths and MEM-stage state encoding for the 19-bit pipelined CPU.
package cpu_pkg;
    localparam int DATA_W  = 19;
    localparam int RD_W    = 3;
    localparam int TIMEOUT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads every cycle, sync reset, bubble_i loads all zeros.
module mem_wb_reg #(
    parameter int DW = 19,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble_i,
    input  logic          regwrite_i,
    input  logic          memtoreg_i,
    input  logic [DW-1:0] out_i,
    input  logic [DW-1:0] rdata_i,
    input  logic [RW-1:0] rd_i,
    output logic          regwrite_o,
    output logic          memtoreg_o,
    output logic [DW-1:0] out_o,
    output logic [DW-1:0] rdata_o,
    output logic [RW-1:0] rd_o
);
    logic          regwrite_q, regwrite_d;
    logic          memtoreg_q, memtoreg_d;
    logic [DW-1:0] out_q, out_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [RW-1:0] rd_q, rd_d;

    always_comb begin
        regwrite_d = regwrite_i;
        memtoreg_d = memtoreg_i;
        out_d      = out_i;
        rdata_d    = rdata_i;
        rd_d       = rd_i;
        if (bubble_i) begin
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            out_d      = '0;
            rdata_d    = '0;
            rd_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            out_q      <= '0;
            rdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            out_q      <= out_d;
            rdata_q    <= rdata_d;
            rd_q       <= rd_d;
        end
    end

    assign regwrite_o = regwrite_q;
    assign memtoreg_o = memtoreg_q;
    assign out_o      = out_q;
    assign rdata_o    = rdata_q;
    assign rd_o       = rd_q;
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory req/ack access with watchdog, upstream stall, and MEM/WB register.
// Latency 1 + wait cycles; stall holds EX/MEM until ack or timeout abort.
module mem_wb_stage #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int RD_W    = cpu_pkg::RD_W,
    parameter int TIMEOUT = cpu_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_regwrite,
    input  logic              MEM_memtoreg,
    input  logic              MEM_memread,
    input  logic              MEM_memwrite,
    input  logic [DATA_W-1:0] MEM_out,
    input  logic [DATA_W-1:0] MEM_wdata,
    input  logic [RD_W-1:0]   MEM_rd,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              WB_regwrite,
    output logic              WB_memtoreg,
    output logic [DATA_W-1:0] WB_out,
    output logic [DATA_W-1:0] WB_rdata,
    output logic [RD_W-1:0]   WB_rd
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              access, timeout_hit, complete, rw_both, bubble;
    logic              wb_memtoreg_in;
    logic [DATA_W-1:0] wb_rdata_in;

    assign access      = MEM_memread | MEM_memwrite;
    assign rw_both     = MEM_memread & MEM_memwrite;
    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

    assign dmem_req   = ~rst & access;
    assign dmem_we    = ~rst & MEM_memwrite;
    assign dmem_addr  = rst ? '0 : MEM_out;
    assign dmem_wdata = rst ? '0 : MEM_wdata;
    assign complete   = dmem_req & dmem_ack;
    assign mem_stall  = dmem_req & ~dmem_ack & ~timeout_hit;
    assign mem_err    = err_q;

    // Anything that touched memory without completing (stalled or aborted) retires as a bubble.
    assign bubble         = access & ~complete;
    assign wb_rdata_in    = (MEM_memread & ~MEM_memwrite & complete) ? dmem_rdata : '0;
    assign wb_memtoreg_in = MEM_memtoreg & ~rw_both;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (access && !dmem_ack) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (!access || dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    mem_wb_reg #(.DW(DATA_W), .RW(RD_W)) u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .bubble_i   (bubble),
        .regwrite_i (MEM_regwrite),
        .memtoreg_i (wb_memtoreg_in),
        .out_i      (MEM_out),
        .rdata_i    (wb_rdata_in),
        .rd_i       (MEM_rd),
        .regwrite_o (WB_regwrite),
        .memtoreg_o (WB_memtoreg),
        .out_o      (WB_out),
        .rdata_o    (WB_rdata),
        .rd_o       (WB_rd)
    );
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboarded bench for mem_wb_stage: expected MEM/WB contents queued per driven cycle.
module tb_mem_wb_stage;
    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [18:0] out;
        logic [18:0] rdata;
        logic [2:0]  rd;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite;
    logic [18:0] MEM_out, MEM_wdata;
    logic [2:0]  MEM_rd;
    logic        mem_stall, mem_err, dmem_req, dmem_we, dmem_ack;
    logic [18:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        WB_regwrite, WB_memtoreg;
    logic [18:0] WB_out, WB_rdata;
    logic [2:0]  WB_rd;

    int  checks = 0;
    int  errors = 0;
    wb_t sb[$];
    wb_t exp_wb;
    wb_t got_wb;
    wb_t bubble_wb;

    always #5 clk = ~clk;

    assign got_wb = {WB_regwrite, WB_memtoreg, WB_out, WB_rdata, WB_rd};

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .MEM_regwrite(MEM_regwrite), .MEM_memtoreg(MEM_memtoreg),
        .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
        .MEM_out(MEM_out), .MEM_wdata(MEM_wdata), .MEM_rd(MEM_rd),
        .mem_stall(mem_stall), .mem_err(mem_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .WB_regwrite(WB_regwrite), .WB_memtoreg(WB_memtoreg),
        .WB_out(WB_out), .WB_rdata(WB_rdata), .WB_rd(WB_rd)
    );

    task automatic drive(input logic rw, input logic mtr, input logic mr, input logic mw,
                         input logic [18:0] out, input logic [18:0] wd, input logic [2:0] rd,
                         input logic ack, input logic [18:0] rdata);
        MEM_regwrite = rw;  MEM_memtoreg = mtr;
        MEM_memread  = mr;  MEM_memwrite = mw;
        MEM_out      = out; MEM_wdata    = wd;  MEM_rd = rd;
        dmem_ack     = ack; dmem_rdata   = rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 19'h12345, 19'h54321, 3'd6, 1'b0, 19'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_stall, dmem_req, dmem_we} !== 3'b000) begin
                errors++; $display("FAIL reset_comb got stall/req/we=%b required 000", {mem_stall, dmem_req, dmem_we});
            end
            @(posedge clk); #1;
            checks++;
            if (got_wb !== bubble_wb || mem_err !== 1'b0) begin
                errors++; $display("FAIL reset_state got wb=%h err=%b required 0/0", got_wb, mem_err);
            end
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 1'b0, 19'h0);
    endtask

    task automatic test_nonmem();
        logic [18:0] o;
        logic [2:0]  r;
        logic        rw, mtr;
        for (int i = 0; i < 5; i++) begin
            o   = (i == 0) ? 19'h1A5A5 : 19'($urandom);
            r   = (i == 0) ? 3'b101 : 3'($urandom);
            rw  = (i == 0) ? 1'b1 : 1'($urandom);
            mtr = (i == 0) ? 1'b0 : 1'($urandom);
            // A stray ack with no request must not leak read data.
            drive(rw, mtr, 1'b0, 1'b0, o, 19'h7AAAA, r, (i > 2), 19'h3C3C3);
            sb.push_back('{rw, mtr, o, 19'h0, r});
            @(negedge clk);
            checks++;
            if ({mem_stall, dmem_req} !== 2'b00) begin
                errors++; $display("FAIL nonmem_stall got stall/req=%b required 00", {mem_stall, dmem_req});
            end
            @(posedge clk); #1;
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb) begin
                errors++; $display("FAIL nonmem_wb got=%h required=%h", got_wb, exp_wb);
            end
        end
    endtask

    task automatic test_zero_wait_load();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 19'h00040, 19'h0, 3'd2, 1'b1, 19'h15A5A);
        sb.push_back('{1'b1, 1'b1, 19'h00040, 19'h15A5A, 3'd2});
        @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req, dmem_we} !== 3'b010 || dmem_addr !== 19'h00040) begin
            errors++; $display("FAIL zw_comb got stall/req/we=%b addr=%h required 010/00040",
                               {mem_stall, dmem_req, dmem_we}, dmem_addr);
        end
        @(posedge clk); #1;
        exp_wb = sb.pop_front();
        checks++;
        if (got_wb !== exp_wb) begin
            errors++; $display("FAIL zw_wb got=%h required=%h", got_wb, exp_wb);
        end
    endtask

    task automatic test_store_wait3();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 19'h7FFFF, 19'h15A5A, 3'd1, (i == 3), 19'h0);
            sb.push_back((i == 3) ? '{1'b0, 1'b0, 19'h7FFFF, 19'h0, 3'd1} : bubble_wb);
            @(negedge clk);
            checks++;
            if (mem_stall !== (i < 3) || dmem_we !== 1'b1 || dmem_addr !== 19'h7FFFF || dmem_wdata !== 19'h15A5A) begin
                errors++; $display("FAIL st_cyc%0d got stall=%b we=%b addr=%h wd=%h required %b/1/7ffff/15a5a",
                                   i, mem_stall, dmem_we, dmem_addr, dmem_wdata, (i < 3));
            end
            @(posedge clk); #1;
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb) begin
                errors++; $display("FAIL st_wb%0d got=%h required=%h", i, got_wb, exp_wb);
            end
        end
    endtask

    task automatic test_timeout_or_late_ack(input logic late_ack);
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 19'h00123, 19'h0, 3'd4, late_ack && (i == 16), 19'h0ABCD);
            sb.push_back((late_ack && i == 16) ? '{1'b1, 1'b1, 19'h00123, 19'h0ABCD, 3'd4} : bubble_wb);
            @(negedge clk);
            checks++;
            if (mem_stall !== (i < 16) || mem_err !== 1'b0) begin
                errors++; $display("FAIL to%0d_cyc%0d got stall=%b err=%b required %b/0",
                                   late_ack, i, mem_stall, mem_err, (i < 16));
            end
            @(posedge clk); #1;
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb) begin
                errors++; $display("FAIL to%0d_wb%0d got=%h required=%h", late_ack, i, got_wb, exp_wb);
            end
        end
        checks++;
        if (mem_err !== !late_ack) begin
            errors++; $display("FAIL to%0d_err got=%b required=%b", late_ack, mem_err, !late_ack);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 19'h00777 + 19'(i), 19'h0, 3'd7, 1'b0, 19'h0);
            sb.push_back('{1'b1, 1'b0, 19'h00777 + 19'(i), 19'h0, 3'd7});
            @(negedge clk);
            checks++;
            if (mem_stall !== 1'b0) begin
                errors++; $display("FAIL to%0d_next_stall got=%b required 0", late_ack, mem_stall);
            end
            @(posedge clk); #1;
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb || mem_err !== !late_ack) begin
                errors++; $display("FAIL to%0d_next%0d got wb=%h err=%b required wb=%h err=%b",
                                   late_ack, i, got_wb, mem_err, exp_wb, !late_ack);
            end
        end
    endtask

    task automatic test_rst_mid_wait();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 19'h00200, 19'h0, 3'd3, 1'b0, 19'h0);
            sb.push_back(bubble_wb);
            @(negedge clk);
            checks++;
            if (mem_stall !== 1'b1) begin
                errors++; $display("FAIL rstw_stall%0d got=%b required 1", i, mem_stall);
            end
            @(posedge clk); #1;
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb) begin
                errors++; $display("FAIL rstw_wb%0d got=%h required=%h", i, got_wb, exp_wb);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req} !== 2'b00) begin
            errors++; $display("FAIL rstw_comb got stall/req=%b required 00", {mem_stall, dmem_req});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (got_wb !== bubble_wb || mem_err !== 1'b0) begin
            errors++; $display("FAIL rstw_state got wb=%h err=%b required 0/0", got_wb, mem_err);
        end
        // Back in IDLE: an immediate ack completes with no stall.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 19'h00200, 19'h0, 3'd3, 1'b1, 19'h12345);
        sb.push_back('{1'b1, 1'b1, 19'h00200, 19'h12345, 3'd3});
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL rstw_resume_stall got=%b required 0", mem_stall);
        end
        @(posedge clk); #1;
        exp_wb = sb.pop_front();
        checks++;
        if (got_wb !== exp_wb) begin
            errors++; $display("FAIL rstw_resume_wb got=%h required=%h", got_wb, exp_wb);
        end
    endtask

    task automatic test_read_write_both();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 19'h00055, 19'h2AAAA, 3'd6, 1'b1, 19'h1FFFF);
        sb.push_back('{1'b1, 1'b0, 19'h00055, 19'h0, 3'd6});
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, mem_stall} !== 3'b110 || dmem_wdata !== 19'h2AAAA) begin
            errors++; $display("FAIL rw_comb got req/we/stall=%b wd=%h required 110/2aaaa",
                               {dmem_req, dmem_we, mem_stall}, dmem_wdata);
        end
        @(posedge clk); #1;
        exp_wb = sb.pop_front();
        checks++;
        if (got_wb !== exp_wb) begin
            errors++; $display("FAIL rw_wb got=%h required=%h", got_wb, exp_wb);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 1'b0, 19'h0);
    endtask

    initial begin
        bubble_wb = '0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 1'b0, 19'h0);
        @(posedge clk); #1;
        test_reset();
        test_nonmem();
        test_zero_wait_load();
        test_store_wait3();
        test_timeout_or_late_ack(1'b0);
        test_rst_mid_wait();
        test_timeout_or_late_ack(1'b1);
        test_read_write_both();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
